// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package fetch_pkg;

    localparam int unsigned PC_STEP          = 4;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries; flush clears pointers and count, reset also clears storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  fetch_entry_t               i_data,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count < CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC, memory address, prefetch FIFO to decode, redirect/flush.
// Optional misaligned-redirect fault is enabled with `define FETCH_MISALIGN_EN.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MEM_AW   = 10
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]    r_pc;
    logic [31:0]    w_target_pc;
    logic           w_fault;
    logic           w_fetch;
    logic           w_pop;
    logic [CW-1:0]  w_count;
    fetch_entry_t   w_push_entry;
    fetch_entry_t   w_head;

`ifdef FETCH_MISALIGN_EN
    logic r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_fault <= |redirect_pc[1:0];
        end
    end

    assign w_target_pc = redirect_pc;
    assign w_fault     = r_fault;
`else
    logic w_unused_lo;

    assign w_unused_lo = ^redirect_pc[1:0];
    assign w_target_pc = {redirect_pc[31:2], 2'b00};
    assign w_fault     = 1'b0;
`endif

    assign out_valid = (w_count != '0) && !redirect_valid && !w_fault;
    assign w_pop     = out_valid && out_ready;
    assign w_fetch   = !rst && !redirect_valid && !w_fault
                       && ((w_count < CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_target_pc;
        end else if (w_fetch) begin
            r_pc <= r_pc + 32'(PC_STEP);
        end
    end

    // Word index split at MEM_AW: the low field is what the memory decodes.
    assign mem_addr = {2'b00, r_pc[31:MEM_AW+2], r_pc[MEM_AW+1:2]};

    assign w_push_entry.pc   = r_pc;
    assign w_push_entry.inst = mem_inst;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign out_inst    = w_head.inst;
    assign out_pc      = w_head.pc;
    assign fetch_fault = w_fault;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a {pc, inst} scoreboard fed from a local instruction memory.
module tb_inst_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    logic [31:0]  mem [1024];
    fetch_entry_t sb_q [$];
    int unsigned  n_total;
    int unsigned  n_pass;
    int unsigned  n_fail;

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2),
        .MEM_AW   (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_inst       (mem_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    assign mem_inst = mem[mem_addr[9:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_restart(input logic [31:0] start, input int unsigned n);
        logic [31:0] pc;
        fetch_entry_t e;
        sb_q.delete();
        for (int unsigned i = 0; i < n; i++) begin
            pc     = start + 32'(i * PC_STEP);
            e.pc   = pc;
            e.inst = mem[pc[11:2]];
            sb_q.push_back(e);
        end
    endtask

    // One clock cycle: sample at the falling edge, return 1 time unit after the rising edge.
    task automatic tick(input logic exp_valid);
        fetch_entry_t e;
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_pop_nonempty", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_inst", out_inst, e.inst);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        for (int unsigned i = 0; i < 1024; i++) begin
            mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem[1023] = NOP_INST;

        rst            = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stream from reset with decode always ready
        sb_restart(32'h0, 16);
        tick(1'b0);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1);
        end

        // Asynchronous reset between edges while valid
        check("pre_async_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out_pc", out_pc, 32'h0);
        check("async_out_inst", out_inst, 32'h0);
        check("async_mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Backpressure right after the first valid
        sb_restart(32'h0, 16);
        out_ready = 1'b0;
        tick(1'b0);
        for (int k = 0; k < 5; k++) begin
            check("stall_head_pc", out_pc, 32'h0);
            check("stall_mem_addr", mem_addr, (k == 0) ? 32'd1 : 32'd2);
            tick(1'b1);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1'b1);
        end

        // Redirect while the FIFO is full
        sb_restart(32'h40, 8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick(1'b0);
        redirect_valid = 1'b0;
        check("redir_mem_addr", mem_addr, 32'h10);
        tick(1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1);
        end

        // Back-to-back redirects: the last target wins
        sb_restart(32'h80, 8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick(1'b0);
        redirect_pc    = 32'h80;
        tick(1'b0);
        redirect_valid = 1'b0;
        check("b2b_mem_addr", mem_addr, 32'h20);
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);

        // PC wrap at the top of the address space
        sb_restart(32'hFFFF_FFFC, 8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick(1'b0);
        redirect_valid = 1'b0;
        check("wrap_mem_addr_top", mem_addr, 32'h3FFF_FFFF);
        tick(1'b0);
        check("wrap_mem_addr_zero", mem_addr, 32'h0);
        tick(1'b1);
        check("wrap_mem_addr_one", mem_addr, 32'h1);
        tick(1'b1);
        tick(1'b1);

        // Misaligned redirect target
`ifdef FETCH_MISALIGN_EN
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        tick(1'b0);
        redirect_valid = 1'b0;
        check("mis_fault_set", 32'(fetch_fault), 32'd1);
        tick(1'b0);
        tick(1'b0);
        check("mis_fault_held", 32'(fetch_fault), 32'd1);
        check("mis_mem_addr", mem_addr, 32'h8);
        sb_restart(32'h20, 4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick(1'b0);
        redirect_valid = 1'b0;
        check("mis_fault_clear", 32'(fetch_fault), 32'd0);
        tick(1'b0);
        tick(1'b1);
`else
        sb_restart(32'h20, 4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        tick(1'b0);
        redirect_valid = 1'b0;
        check("mis_fault_zero", 32'(fetch_fault), 32'd0);
        check("mis_mem_addr", mem_addr, 32'h8);
        tick(1'b0);
        tick(1'b1);
        check("mis_fault_still_zero", 32'(fetch_fault), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
